// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Central hazard and stall controller for the 5-stage pipeline.
// It produces:
//   - EX-stage forwarding selects;
//   - load-use stall and control-hazard flush signals;
//   - memory-wait hold signals for every pipeline register.
// A small FSM tracks an outstanding data-memory access and latches a sticky
// timeout error.
// Optional feature macro: HAZARD_PERF_EN adds stall/flush cycle counters on
// ports stall_cnt_o and flush_cnt_o.
module hazard_stall_ctrl #(
    parameter int DMEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1D_i,
    input  logic [4:0]  rs2D_i,
    input  logic [4:0]  rs1E_i,
    input  logic [4:0]  rs2E_i,
    input  logic [4:0]  rdE_i,
    input  logic [4:0]  rdM_i,
    input  logic [4:0]  rdW_i,
    input  logic [1:0]  resultsrcE_i,
    input  logic        regwriteM_i,
    input  logic        regwriteW_i,
    input  logic        pcsrcE_i,
    input  logic        memreqM_i,
    input  logic        dmem_ready_i,
    output logic [1:0]  forwardAE_o,
    output logic [1:0]  forwardBE_o,
    output logic        stallF_o,
    output logic        stallD_o,
    output logic        stallE_o,
    output logic        stallM_o,
    output logic        flushD_o,
    output logic        flushE_o,
    output logic        flushW_o,
    output logic        dmem_err_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DMEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dmemErr;

    logic             w_memStall;
    logic             w_holdAll;
    logic             w_lwStall;
    logic [CNT_W-1:0] w_cntInc;

    // Forwarding select for operand A: the younger MEM result beats WB.
    always_comb begin
        forwardAE_o = 2'b00;
        if (regwriteM_i && (rdM_i != 5'd0) && (rdM_i == rs1E_i)) begin
            forwardAE_o = 2'b10;
        end else if (regwriteW_i && (rdW_i != 5'd0) && (rdW_i == rs1E_i)) begin
            forwardAE_o = 2'b01;
        end
    end

    // Forwarding select for operand B, same priority as operand A.
    always_comb begin
        forwardBE_o = 2'b00;
        if (regwriteM_i && (rdM_i != 5'd0) && (rdM_i == rs2E_i)) begin
            forwardBE_o = 2'b10;
        end else if (regwriteW_i && (rdW_i != 5'd0) && (rdW_i == rs2E_i)) begin
            forwardBE_o = 2'b01;
        end
    end

    // Hazard detection.
    // A memory wait only counts while the FSM can still accept the access.
    // Once in ERR, the pipeline stays frozen regardless of the inputs.
    always_comb begin
        w_memStall = 1'b0;
        if (r_state != S_ERR) begin
            w_memStall = memreqM_i && !dmem_ready_i;
        end
        w_holdAll = w_memStall || (r_state == S_ERR);
        w_lwStall = (resultsrcE_i == 2'b01) && (rdE_i != 5'd0) &&
                    ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
        w_cntInc  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    end

    // Stall and flush drivers.
    // A memory hold freezes every stage and bubbles WB.
    // It suppresses the load-use and branch flushes so that held instructions
    // are not killed; those hazards are re-evaluated once the hold releases.
    always_comb begin
        stallF_o = w_holdAll || w_lwStall;
        stallD_o = w_holdAll || w_lwStall;
        stallE_o = w_holdAll;
        stallM_o = w_holdAll;
        flushW_o = w_holdAll;
        flushD_o = !w_holdAll && pcsrcE_i;
        flushE_o = !w_holdAll && (w_lwStall || pcsrcE_i);
    end

    // Memory access FSM.
    // The wait counter runs while the access stays unready.
    // The state moves to the absorbing ERR state on the DMEM_TIMEOUT-th
    // edge after the first stalled cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dmemErr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_memStall) begin
                        if (DMEM_TIMEOUT <= 1) begin
                            r_state   <= S_ERR;
                            r_dmemErr <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!memreqM_i || dmem_ready_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                        if (w_cntInc >= CNT_LAST) begin
                            r_state   <= S_ERR;
                            r_dmemErr <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    r_state   <= S_ERR;
                    r_dmemErr <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign dmem_err_o = r_dmemErr;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;

    // Performance counters.
    // They count cycles with a front-end stall and cycles with an ID/EX flush,
    // and wrap freely at 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (stallF_o) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (flushE_o) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;
    assign flush_cnt_o = r_flushCnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed-vector bench for hazard_stall_ctrl with a cycle-level reference
// model. Honours HAZARD_PERF_EN when the macro is defined.
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic [4:0] rs1D;
        logic [4:0] rs2D;
        logic [4:0] rs1E;
        logic [4:0] rs2E;
        logic [4:0] rdE;
        logic [4:0] rdM;
        logic [4:0] rdW;
        logic [1:0] resultsrcE;
        logic       regwriteM;
        logic       regwriteW;
        logic       pcsrcE;
        logic       memreqM;
        logic       dmemReady;
    } stim_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0;
    logic [4:0]  rdE = '0, rdM = '0, rdW = '0;
    logic [1:0]  resultsrcE = '0;
    logic        regwriteM = 1'b0, regwriteW = 1'b0, pcsrcE = 1'b0;
    logic        memreqM = 1'b0, dmemReady = 1'b0;
    logic [1:0]  forwardAE, forwardBE;
    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushW, dmemErr;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt, flushCnt;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state: consecutive stalled-access cycles and sticky error.
    int          mRun = 0;
    bit          mErr = 1'b0;
    logic [31:0] mStallCnt = '0;
    logic [31:0] mFlushCnt = '0;

    hazard_stall_ctrl #(.DMEM_TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rs1D_i       (rs1D),
        .rs2D_i       (rs2D),
        .rs1E_i       (rs1E),
        .rs2E_i       (rs2E),
        .rdE_i        (rdE),
        .rdM_i        (rdM),
        .rdW_i        (rdW),
        .resultsrcE_i (resultsrcE),
        .regwriteM_i  (regwriteM),
        .regwriteW_i  (regwriteW),
        .pcsrcE_i     (pcsrcE),
        .memreqM_i    (memreqM),
        .dmem_ready_i (dmemReady),
        .forwardAE_o  (forwardAE),
        .forwardBE_o  (forwardBE),
        .stallF_o     (stallF),
        .stallD_o     (stallD),
        .stallE_o     (stallE),
        .stallM_o     (stallM),
        .flushD_o     (flushD),
        .flushE_o     (flushE),
        .flushW_o     (flushW),
        .dmem_err_o   (dmemErr)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o  (stallCnt),
        .flush_cnt_o  (flushCnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Compare process: every falling edge, derive the expected outputs from
    // the hazard rules and the model's memory history, compare them, and
    // then advance the model by the cycle about to close.
    always @(negedge clk_i) begin
        bit hold, lw, memStallNow;
        bit expStallF, expFlushD, expFlushE;
        if (!rst_i) begin
            mRun = 0;
            mErr = 1'b0;
            mStallCnt = '0;
            mFlushCnt = '0;
        end
        memStallNow = memreqM && !dmemReady;
        hold = mErr || memStallNow;
        lw = (resultsrcE == 2'b01) && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
        expStallF = hold || lw;
        expFlushD = !hold && pcsrcE;
        expFlushE = !hold && (lw || pcsrcE);
        checkOutput("cyc_forwardAE", 32'(forwardAE), 32'(fwdSel(rs1E)));
        checkOutput("cyc_forwardBE", 32'(forwardBE), 32'(fwdSel(rs2E)));
        checkOutput("cyc_stallF", 32'(stallF), 32'(expStallF));
        checkOutput("cyc_stallD", 32'(stallD), 32'(expStallF));
        checkOutput("cyc_stallE", 32'(stallE), 32'(hold));
        checkOutput("cyc_stallM", 32'(stallM), 32'(hold));
        checkOutput("cyc_flushD", 32'(flushD), 32'(expFlushD));
        checkOutput("cyc_flushE", 32'(flushE), 32'(expFlushE));
        checkOutput("cyc_flushW", 32'(flushW), 32'(hold));
        checkOutput("cyc_dmemErr", 32'(dmemErr), 32'(mErr));
`ifdef HAZARD_PERF_EN
        checkOutput("cyc_stallCnt", stallCnt, mStallCnt);
        checkOutput("cyc_flushCnt", flushCnt, mFlushCnt);
`endif
        if (rst_i) begin
            if (expStallF) mStallCnt = mStallCnt + 32'd1;
            if (expFlushE) mFlushCnt = mFlushCnt + 32'd1;
            if (!mErr) begin
                if (memStallNow) begin
                    mRun++;
                    if (mRun >= TIMEOUT) mErr = 1'b1;
                end else begin
                    mRun = 0;
                end
            end
        end
    end

    // Drive one input vector just after a rising edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk_i);
        #1;
        rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        rdE = s.rdE; rdM = s.rdM; rdW = s.rdW;
        resultsrcE = s.resultsrcE;
        regwriteM = s.regwriteM; regwriteW = s.regwriteW;
        pcsrcE = s.pcsrcE; memreqM = s.memreqM; dmemReady = s.dmemReady;
        #1;
    endtask

    // Assert reset asynchronously mid-cycle with idle inputs, check, then release.
    task automatic doReset();
        stim_t z;
        z = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rs1D = z.rs1D; rs2D = z.rs2D; rs1E = z.rs1E; rs2E = z.rs2E;
        rdE = z.rdE; rdM = z.rdM; rdW = z.rdW; resultsrcE = z.resultsrcE;
        regwriteM = 0; regwriteW = 0; pcsrcE = 0; memreqM = 0; dmemReady = 0;
        #1;
        checkOutput("rst_stallF", 32'(stallF), 32'd0);
        checkOutput("rst_stallM", 32'(stallM), 32'd0);
        checkOutput("rst_flushE", 32'(flushE), 32'd0);
        checkOutput("rst_flushW", 32'(flushW), 32'd0);
        checkOutput("rst_dmemErr", 32'(dmemErr), 32'd0);
        checkOutput("rst_forwardAE", 32'(forwardAE), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        stim_t s;
        doReset();

        // Forwarding: MEM beats WB, then WB alone, then register x0 never forwards.
        s = '0;
        s.rs1E = 5; s.rs2E = 5; s.rdM = 5; s.regwriteM = 1; s.rdW = 5; s.regwriteW = 1;
        applyStimulus(s);
        checkOutput("fwd_mem_A", 32'(forwardAE), 32'b10);
        checkOutput("fwd_mem_B", 32'(forwardBE), 32'b10);
        s.regwriteM = 0;
        applyStimulus(s);
        checkOutput("fwd_wb_A", 32'(forwardAE), 32'b01);
        s.rdM = 0; s.rdW = 0; s.regwriteM = 1;
        applyStimulus(s);
        checkOutput("fwd_x0_A", 32'(forwardAE), 32'b00);

        // Load-use on rs2D, then the same with rdE = x0.
        s = '0;
        s.resultsrcE = 2'b01; s.rdE = 7; s.rs2D = 7;
        applyStimulus(s);
        checkOutput("lw_stallF", 32'(stallF), 32'd1);
        checkOutput("lw_stallD", 32'(stallD), 32'd1);
        checkOutput("lw_flushE", 32'(flushE), 32'd1);
        checkOutput("lw_flushD", 32'(flushD), 32'd0);
        checkOutput("lw_stallE", 32'(stallE), 32'd0);
        s.rdE = 0;
        applyStimulus(s);
        checkOutput("lw_x0_stallF", 32'(stallF), 32'd0);
        checkOutput("lw_x0_flushE", 32'(flushE), 32'd0);

        // Branch taken together with a load-use.
        s.rdE = 7; s.pcsrcE = 1;
        applyStimulus(s);
        checkOutput("br_lw_flushD", 32'(flushD), 32'd1);
        checkOutput("br_lw_flushE", 32'(flushE), 32'd1);

        // Three wait cycles with a concurrent branch, then ready.
        s = '0;
        s.memreqM = 1; s.pcsrcE = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput("memw_stallM", 32'(stallM), 32'd1);
            checkOutput("memw_flushW", 32'(flushW), 32'd1);
            checkOutput("memw_flushD", 32'(flushD), 32'd0);
            checkOutput("memw_flushE", 32'(flushE), 32'd0);
        end
        s.pcsrcE = 0; s.dmemReady = 1;
        applyStimulus(s);
        checkOutput("memrdy_stallF", 32'(stallF), 32'd0);
        checkOutput("memrdy_flushW", 32'(flushW), 32'd0);
        checkOutput("memrdy_dmemErr", 32'(dmemErr), 32'd0);

        // An access ready in its first MEM cycle does not stall.
        applyStimulus(s);
        checkOutput("mem0_stallE", 32'(stallE), 32'd0);

        // Timeout: ready held low; the error appears after the TIMEOUT-th edge.
        s = '0;
        s.memreqM = 1;
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(s);
        checkOutput("to_pre_dmemErr", 32'(dmemErr), 32'd0);
        s.memreqM = 0;
        applyStimulus(s);
        checkOutput("to_dmemErr", 32'(dmemErr), 32'd1);
        checkOutput("to_err_stallF", 32'(stallF), 32'd1);
        checkOutput("to_err_flushW", 32'(flushW), 32'd1);
        applyStimulus(s);
        checkOutput("to_sticky_dmemErr", 32'(dmemErr), 32'd1);
        doReset();
        applyStimulus(s);
        checkOutput("post_rst_stallF", 32'(stallF), 32'd0);

`ifdef HAZARD_PERF_EN
        // Counters: three memory-stall cycles plus one load-use cycle.
        doReset();
        s = '0;
        s.memreqM = 1;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.dmemReady = 1;
        applyStimulus(s);
        s = '0;
        s.resultsrcE = 2'b01; s.rdE = 3; s.rs1D = 3;
        applyStimulus(s);
        s = '0;
        applyStimulus(s);
        checkOutput("perf_stallCnt", stallCnt, 32'd4);
        checkOutput("perf_flushCnt", flushCnt, 32'd1);
`endif

        repeat (2) @(posedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
